// File: rtl/spi_adc_responder_if.sv
// Sample stream and SPI pin bundle for the emulated ADC channel.
// The master side is the sample source and the SPI capture block; the slave side is the responder.
interface spi_adc_responder_if #(
  parameter int DATA_W = 10
);
  logic              spi_clk;
  logic              cs;
  logic              sdo;
  logic              sdo_oe;
  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;

  modport master (
    output spi_clk, cs, s_data, s_valid,
    input  sdo, sdo_oe, s_ready
  );

  modport slave (
    input  spi_clk, cs, s_data, s_valid,
    output sdo, sdo_oe, s_ready
  );
endinterface

// File: rtl/spi_adc_responder.sv
// SPI responder emulating one 10-bit ADC channel: buffers samples in a small FIFO
// and shifts each one out MSB-first, framed by zeros, on spi_clk falling edges.
module spi_adc_responder #(
  parameter int DATA_W      = 10,
  parameter int LEAD_ZEROS  = 3,
  parameter int FRAME_BITS  = 16,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  spi_adc_responder_if.slave   bus,
  input  logic                 underrun_clr,
  output logic                 underrun,
  output logic                 busy,
  output logic [15:0]          frame_count,
  output logic [7:0]           abort_count
);

  localparam int TRAIL_ZEROS = FRAME_BITS - LEAD_ZEROS - DATA_W;
  localparam int PTR_W       = $clog2(FIFO_DEPTH);
  localparam int CNT_W       = $clog2(FRAME_BITS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_BITS - 2);
  localparam logic [PTR_W:0]   FULL_OCC = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  state_t                  state_reg;
  logic [SYNC_STAGES-1:0]  sclk_sync_reg;
  logic [SYNC_STAGES-1:0]  cs_sync_reg;
  logic                    sclk_last_reg;
  logic                    cs_last_reg;
  logic [FRAME_BITS-1:0]   shreg_reg;
  logic [CNT_W-1:0]        bit_cnt_reg;
  logic                    sdo_reg;
  logic [DATA_W-1:0]       last_sample_reg;
  logic                    underrun_reg;
  logic [15:0]             frame_count_reg;
  logic [7:0]              abort_count_reg;

  logic [DATA_W-1:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_reg;
  logic [PTR_W-1:0]        rd_ptr_reg;
  logic [PTR_W:0]          occ_reg;

  logic                    sclk_s;
  logic                    cs_s;
  logic                    sclk_fall;
  logic                    cs_fall;
  logic                    fifo_nonempty;
  logic                    push;
  logic                    load;
  logic                    pop;
  logic [DATA_W-1:0]       load_sample;
  logic [FRAME_BITS-1:0]   load_word;

  // Pin synchronisers plus one edge-detect register; idle levels are spi_clk=0, cs=1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_sync_reg <= '0;
      cs_sync_reg   <= '1;
      sclk_last_reg <= 1'b0;
      cs_last_reg   <= 1'b1;
    end else begin
      sclk_sync_reg[0] <= bus.spi_clk;
      cs_sync_reg[0]   <= bus.cs;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sclk_sync_reg[i] <= sclk_sync_reg[i-1];
        cs_sync_reg[i]   <= cs_sync_reg[i-1];
      end
      sclk_last_reg <= sclk_s;
      cs_last_reg   <= cs_s;
    end
  end

  assign sclk_s    = sclk_sync_reg[SYNC_STAGES-1];
  assign cs_s      = cs_sync_reg[SYNC_STAGES-1];
  assign sclk_fall = sclk_last_reg & ~sclk_s;
  assign cs_fall   = cs_last_reg & ~cs_s;

  assign fifo_nonempty = (occ_reg != '0);
  assign bus.s_ready   = (occ_reg < FULL_OCC);
  assign push          = bus.s_valid & bus.s_ready;
  assign load          = (state_reg == IDLE) & cs_fall;
  // A push landing on an empty FIFO during a load is not bypassed: pop needs registered occupancy.
  assign pop           = load & fifo_nonempty;

  assign load_sample = fifo_nonempty ? mem[rd_ptr_reg] : last_sample_reg;
  assign load_word   = FRAME_BITS'(load_sample) << TRAIL_ZEROS;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= bus.s_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      occ_reg    <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push, pop})
        2'b10:   occ_reg <= occ_reg + (PTR_W + 1)'(1);
        2'b01:   occ_reg <= occ_reg - (PTR_W + 1)'(1);
        default: occ_reg <= occ_reg;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= IDLE;
      shreg_reg       <= '0;
      bit_cnt_reg     <= '0;
      sdo_reg         <= 1'b0;
      last_sample_reg <= '0;
      underrun_reg    <= 1'b0;
      frame_count_reg <= '0;
      abort_count_reg <= '0;
    end else begin
      // A new underrun beats a coincident clear.
      underrun_reg <= (underrun_reg & ~underrun_clr) | (load & ~fifo_nonempty);
      case (state_reg)
        IDLE: begin
          sdo_reg <= 1'b0;
          if (cs_fall) begin
            state_reg   <= SHIFT;
            shreg_reg   <= load_word;
            bit_cnt_reg <= '0;
            sdo_reg     <= load_word[FRAME_BITS-1];
            if (fifo_nonempty) last_sample_reg <= mem[rd_ptr_reg];
          end
        end
        SHIFT: begin
          // cs rising outranks a coincident spi_clk fall.
          if (cs_s) begin
            state_reg <= IDLE;
            sdo_reg   <= 1'b0;
            if (abort_count_reg != 8'hFF) abort_count_reg <= abort_count_reg + 8'd1;
          end else if (sclk_fall) begin
            bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
            shreg_reg   <= shreg_reg << 1;
            sdo_reg     <= shreg_reg[FRAME_BITS-2];
            if (bit_cnt_reg == LAST_CNT) begin
              state_reg       <= HOLD;
              sdo_reg         <= 1'b0;
              frame_count_reg <= frame_count_reg + 16'd1;
            end
          end
        end
        HOLD: begin
          sdo_reg <= 1'b0;
          if (cs_s) state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
          sdo_reg   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sdo     = sdo_reg;
  assign bus.sdo_oe  = ~cs_s;
  assign underrun    = underrun_reg;
  assign busy        = (state_reg == SHIFT);
  assign frame_count = frame_count_reg;
  assign abort_count = abort_count_reg;

endmodule

// File: tb/tb_spi_adc_responder.sv
// Randomised bench for spi_adc_responder: a queue-based model predicts each frame's
// serial word, FIFO flow control, underrun flag and frame/abort counters.
module tb_spi_adc_responder;
  localparam int PH = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        underrun_clr = 1'b0;
  logic        underrun;
  logic        busy;
  logic [15:0] frame_count;
  logic [7:0]  abort_count;

  spi_adc_responder_if #(.DATA_W(10)) bus ();

  spi_adc_responder dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus.slave),
    .underrun_clr (underrun_clr),
    .underrun     (underrun),
    .busy         (busy),
    .frame_count  (frame_count),
    .abort_count  (abort_count)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [9:0]  m_q[$];
  logic [9:0]  m_last;
  logic        m_under;
  logic [15:0] m_fc;
  int          m_ac;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_q.delete();
    m_last  = '0;
    m_under = 1'b0;
    m_fc    = '0;
    m_ac    = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sdo"}, bus.sdo, 0);
    check({tag, "_sdo_oe"}, bus.sdo_oe, 0);
    check({tag, "_s_ready"}, bus.s_ready, 1);
    check({tag, "_underrun"}, underrun, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_frame_count"}, frame_count, 0);
    check({tag, "_abort_count"}, abort_count, 0);
  endtask

  task automatic push(input logic [9:0] d);
    check("s_ready_pre", bus.s_ready, (m_q.size() < 4));
    bus.s_data  = d;
    bus.s_valid = 1'b1;
    tick(1);
    bus.s_valid = 1'b0;
    if (m_q.size() < 4) m_q.push_back(d);
    check("s_ready_post", bus.s_ready, (m_q.size() < 4));
    $display("push %03h occupancy=%0d", d, m_q.size());
  endtask

  task automatic clr_pulse();
    underrun_clr = 1'b1;
    tick(1);
    underrun_clr = 1'b0;
    m_under = 1'b0;
    check("underrun_clr", underrun, 0);
  endtask

  // One frame of nbits SPI clock cycles (ph clk cycles per phase); nbits < 15 ends as an abort.
  task automatic frame(input int nbits, input int ph, input bit clr_hold);
    logic [15:0] cap;
    logic [15:0] word;
    logic [9:0]  samp;
    int          w;
    cap = '0;
    if (m_q.size() > 0) begin
      samp   = m_q.pop_front();
      m_last = samp;
      if (clr_hold) m_under = 1'b0;
    end else begin
      samp    = m_last;
      m_under = 1'b1;
    end
    word = {3'b000, samp, 3'b000};

    bus.cs       = 1'b0;
    underrun_clr = clr_hold;
    w = 0;
    while (!busy && w < 20) begin
      tick(1);
      w++;
    end
    underrun_clr = 1'b0;
    check("busy_start", busy, 1);
    tick(ph);
    check("sdo_oe_active", bus.sdo_oe, 1);
    for (int i = 0; i < nbits; i++) begin
      cap = {cap[14:0], bus.sdo};
      bus.spi_clk = 1'b1;
      tick(ph);
      bus.spi_clk = 1'b0;
      tick(ph);
    end
    bus.cs = 1'b1;
    if (nbits >= 15) m_fc = m_fc + 16'd1;
    else if (m_ac < 255) m_ac++;
    tick(4);
    check("sdo_idle", bus.sdo, 0);
    check("sdo_oe_idle", bus.sdo_oe, 0);
    check("busy_end", busy, 0);
    check("frame_count", frame_count, m_fc);
    check("abort_count", abort_count, m_ac);
    check("underrun", underrun, m_under);
    check("s_ready", bus.s_ready, (m_q.size() < 4));
    if (nbits > 0) check("frame_data", cap, word >> (16 - nbits));
    $display("frame bits=%0d data=%04h expected=%04h fc=%0d ac=%0d underrun=%0b",
             nbits, cap, word >> (16 - nbits), frame_count, abort_count, underrun);
    tick(2);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.spi_clk = 1'b0;
    bus.cs      = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    model_reset();
    tick(3);
    check_reset_outputs("reset");
    reset = 1'b0;
    tick(4);

    // Single frame of a known sample: 16'h1528 expected
    push(10'h2A5);
    frame(16, PH, 1'b0);

    // Overfill: fifth push is refused, then four frames drain in push order
    for (int i = 0; i < 5; i++) push(10'($urandom));
    for (int i = 0; i < 4; i++) frame(16, PH, 1'b0);

    // Underrun repeats the last sample; clear pulse; clear held across a new underrun
    push(10'h3FF);
    frame(16, PH, 1'b0);
    frame(16, PH, 1'b0);
    clr_pulse();
    frame(16, PH, 1'b1);
    check("underrun_set_wins", underrun, 1);
    clr_pulse();

    // Abort after 7 clocks, then the next entry is popped
    push(10'h155);
    push(10'($urandom));
    frame(7, PH, 1'b0);
    frame(16, PH, 1'b0);

    // Random mix of pushes, clears, full and aborted frames at varied phase lengths
    for (int it = 0; it < 30; it++) begin
      int k;
      int nb;
      k = $urandom_range(0, 3);
      for (int j = 0; j < k; j++) push(10'($urandom));
      if ($urandom_range(0, 3) == 0) clr_pulse();
      if ($urandom_range(0, 3) == 0) nb = $urandom_range(0, 14);
      else nb = $urandom_range(15, 16);
      frame(nb, $urandom_range(4, 9), 1'b0);
    end

    // frame_count wrap
    force dut.frame_count_reg = 16'hFFFF;
    tick(1);
    release dut.frame_count_reg;
    m_fc = 16'hFFFF;
    tick(1);
    check("frame_count_preload", frame_count, 16'hFFFF);
    frame(16, 4, 1'b0);
    check("frame_count_wrap", frame_count, 0);

    // abort_count saturation
    for (int i = 0; i < 300; i++) frame(1, 4, 1'b0);
    check("abort_saturate", abort_count, 255);

    // Reset mid-frame with three samples queued
    for (int i = 0; i < 3; i++) push(10'($urandom));
    bus.cs = 1'b0;
    tick(PH);
    for (int i = 0; i < 9; i++) begin
      bus.spi_clk = 1'b1;
      tick(PH);
      bus.spi_clk = 1'b0;
      tick(PH);
    end
    reset = 1'b1;
    tick(1);
    check_reset_outputs("midreset");
    bus.cs = 1'b1;
    tick(2);
    reset = 1'b0;
    model_reset();
    tick(4);
    frame(16, PH, 1'b0);
    check("post_reset_underrun", underrun, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/spi_adc_responder.md
Name: spi_adc_responder

Overview:
- Synthesisable SPI responder that emulates one 10-bit ADC channel as seen by the SPI capture block that reads adc1..adc4.
- Used for hardware-in-loop and loopback tests of the acquisition, ring-buffer and trigger chain: it is wired in place of a real converter.
- Samples arrive on a valid/ready stream, are buffered in a small FIFO, and are shifted out MSB-first on the serial data line while the ADC's chip select is low.

Parameters:
- DATA_W, 10, sample width in bits
- LEAD_ZEROS, 3, zero bits driven before the sample MSB
- FRAME_BITS, 16, SPI clock cycles per complete frame (trailing zeros = FRAME_BITS - LEAD_ZEROS - DATA_W)
- FIFO_DEPTH, 4, sample FIFO entries (power of 2)
- SYNC_STAGES, 2, synchroniser flops on spi_clk and cs

Ports:
- clk  in  1  system clock; the only clock in the block
- reset  in  1  asynchronous, active-high reset
- spi_clk  in  1  SPI clock from the capture master; asynchronous, synchronised internally
- cs  in  1  active-low chip select from the master; asynchronous, synchronised internally
- sdo  out  1  serial data to the master
- sdo_oe  out  1  high while cs (synchronised) is low
- s_data  in  DATA_W  sample to transmit
- s_valid  in  1  s_data valid
- s_ready  out  1  FIFO not full
- underrun  out  1  sticky flag: a frame started with the FIFO empty
- underrun_clr  in  1  single-cycle clear of underrun
- busy  out  1  frame in progress (state SHIFT)
- frame_count  out  16  number of completed frames, wraps at 16'hFFFF -> 0
- abort_count  out  8  number of frames ended early by cs rising, saturates at 255

Behaviour:
- Reset values: sdo=0, sdo_oe=0, s_ready=1, underrun=0, busy=0, frame_count=0, abort_count=0; FIFO empty; last_sample=0; state IDLE; synchroniser flops cleared (spi_clk=0, cs=1).
- Input timing: spi_clk and cs pass through SYNC_STAGES flops, followed by one edge-detect register. Edge events therefore lag the pins by SYNC_STAGES+1 clk cycles.
- Master constraint: each SPI clock phase must last at least SYNC_STAGES+2 clk cycles.
- FIFO:
  - A push occurs when s_valid & s_ready.
  - s_ready = (occupancy < FIFO_DEPTH), combinational from the registered occupancy.
  - A push and a pop in the same cycle leave occupancy unchanged.
  - A push into an empty FIFO in the same cycle as a load is not bypassed; the load takes the underrun path.
- State machine: IDLE, SHIFT, HOLD.
  - IDLE -> SHIFT on a cs falling edge (load):
    - If the FIFO is non-empty: pop it; the popped word is also written to last_sample.
    - If the FIFO is empty: use last_sample and set underrun.
    - shreg = {LEAD_ZEROS zeros, sample, trailing zeros}; bit_cnt=0.
    - sdo = shreg MSB (0) on the same cycle.
  - SHIFT, on each spi_clk falling edge: bit_cnt++, shreg shifts left by one, and sdo = the new MSB.
  - SHIFT -> HOLD on the falling edge at which bit_cnt reaches FRAME_BITS-1. sdo = 0 from this point; frame_count increments once.
  - Any state with cs high -> IDLE.
    - A cs rising edge in SHIFT increments abort_count (saturating).
    - A frame that has reached HOLD is complete; its cs rise is not an abort.
  - spi_clk rising edges never change sdo; the master samples on the rising edge.
- Glitch and ordering rules:
  - A cs rising and falling within the synchroniser window may be lost; no recovery is required.
  - A spi_clk falling edge in the same cycle as a cs rising edge: the cs rise wins.
- sdo_oe = synchronised ~cs. sdo = 0 whenever state is IDLE.
- underrun_clr coinciding with a new underrun: the set wins, so underrun stays 1.
- busy = (state == SHIFT).
- Reset asserted mid-frame: immediate return to the reset values; FIFO contents are discarded.

Test Plan:
- Push 10'h2A5, then run one 16-clock frame (8 clk cycles per phase) -> master samples 000 1010100101 000 = 16'h1528; frame_count=1; underrun=0; s_ready=1.
- Push 5 samples with no frames running -> the first 4 are accepted and s_ready drops to 0 after the 4th; 4 frames then return the samples in push order; s_ready returns to 1 after the first pop.
- Push 10'h3FF, run 2 frames -> second frame repeats 10'h3FF (16'h1FF8) and underrun=1; underrun_clr pulse -> underrun=0; underrun_clr held during a further underrun -> underrun stays 1.
- Push 10'h155, raise cs after 7 spi_clk cycles -> abort_count=1, frame_count unchanged, sdo=0 and sdo_oe=0 after the synchroniser delay; the next frame pops the next FIFO entry.
- Preload frame_count=16'hFFFF via 65535 fast frames (or a force) plus 1 frame -> 0; 300 aborted frames -> abort_count=255.
- Assert reset at bit 9 of a frame with 3 samples queued -> all outputs at reset values within 1 cycle; s_ready=1; a later frame with the FIFO empty sends 10'h000 and sets underrun.
